stall_ctrl: RTL and testbench
=============================

// Module: stall_ctrl
// PURPOSE
//  Pipeline hazard/stall controller for the forwarding network. Forwarding serves ALU results from
//  EX/DCACHE/MEM; stall_ctrl covers what it cannot: load-use hazards, DCACHE miss waits, divider busy.
//  Emits a per-stage stall vector and an EX bubble; sits beside the ID stage, driven by pipeline tags.
// PARAMETERS
//  STALL_W   6   stall vector width: [0]PC [1]IF [2]ID [3]EX [4]DCACHE [5]MEM
//  PERF_W    32  width of perf counters (macro-gated)
// PORTS
//  clk            in   1       clock, rising edge
//  rst            in   1       reset, asynchronous, active-high
//  flush          in   1       exception/eret flush; kills all pending stall state
//  id_valid       in   1       ID holds a real instruction
//  id_rs_ren      in   1       ID reads rs
//  id_rs_raddr    in   5       rs address (`RegAddrBus)
//  id_rt_ren      in   1       ID reads rt
//  id_rt_raddr    in   5       rt address
//  ex_we/ex_load  in   1/1     EX writes GPR / EX op is a load
//  ex_waddr       in   5       EX destination
//  dc_we/dc_load  in   1/1     DCACHE stage writes GPR / is a load
//  dc_waddr       in   5       DCACHE destination
//  dcache_miss    in   1       DCACHE stage waiting on memory (level)
//  div_start      in   1       EX issues a divide this cycle (pulse)
//  div_ready      in   1       divider result valid (pulse)
//  stall          out  6       per-stage hold; stage i holds when stall[i]=1
//  ex_bubble      out  1       insert NOP into EX next edge
//  perf_stall_cnt out  PERF_W  total stalled cycles (0 when macro off)
//  perf_lu_cnt    out  PERF_W  load-use stall cycles (0 when macro off)
// BEHAVIOUR
//  - States: RUN, LU_WAIT, DIV_WAIT, MISS_WAIT. Reset -> RUN, lu_cnt=0, stall=0, ex_bubble=0, counters=0.
//  - Load-use hit: id_valid & ((rs_ren & rs==P) | (rt_ren & rt==P)), P a load dst, P!=0 ($0 never hazards).
//  - Load in EX -> 2 bubble cycles; load only in DCACHE -> 1. Both hit: 2. Mealy: stall[2:0]=3'b111 and
//    ex_bubble=1 in the detect cycle; if 2 needed -> LU_WAIT, lu_cnt=1, one more cycle, then RUN.
//  - DIV: div_start -> DIV_WAIT next edge; stall[3:0]=4'hF, ex_bubble=0 until div_ready; RUN edge after.
//    div_start with div_ready same cycle (1-cycle div): no stall.
//  - MISS: dcache_miss=1 -> stall[4:0]=5'h1F combinationally, same cycle; MISS_WAIT until it drops.
//    MEM never stalled (stall[5]=0 always; keeps older results retiring).
//  - Priority: flush > dcache_miss > DIV_WAIT > load-use. Miss during LU_WAIT/DIV_WAIT: miss stall
//    overrides; lu_cnt/div state frozen and resumed when miss clears.
//  - Load-use detect suppressed while stall[3]=1 (EX frozen; re-evaluated when EX moves).
//  - flush: same cycle stall=0, ex_bubble=0; next edge -> RUN, lu_cnt=0, div wait aborted.
//  - rst asserted mid-stall: outputs 0 immediately (async), state RUN.
// CONFIGURATION
//  STALL_CTRL_PERF_EN defined: perf_stall_cnt +1 each cycle stall!=0; perf_lu_cnt +1 per load-use
//    stall cycle; both wrap at 2^PERF_W, clear on rst only (not flush).
//  Undefined: no counter flops; both outputs tied 0.
// STRUCTURE
//  lib/defines.vh: `RegAddrBus, `StallBus, stage-index constants STALL_PC..STALL_MEM, FSM state codes.
//  Sub-module load_use_detect (combinational: ID srcs vs EX/DCACHE load dsts -> hit, need_two).
//  Top: FSM, lu_cnt, output decode, macro-gated perf counters.
// TESTING
//  1 lw $5 in EX, ID add reads $5 -> stall=6'h07, ex_bubble=1 for 2 cycles, then 0; perf_lu_cnt=2.
//  2 lw $5 in DCACHE only, ID reads rt=$5 -> exactly 1 stall cycle; lw $0 dst -> no stall.
//  3 div_start, div_ready 5 cycles later -> stall=6'h0F for 5 cycles, RUN on next edge.
//  4 dcache_miss 3 cycles during LU_WAIT -> stall=6'h1F x3, then remaining 1 load-use cycle.
//  5 flush during DIV_WAIT -> stall=0 same cycle, RUN next edge, later div_ready ignored.
//  6 rst pulsed mid-MISS_WAIT -> stall=0 asynchronously; counters 0 (macro on) / tied 0 (off).

Source files
------------

// File: rtl/stall_ctrl_pkg.sv
// rtl/stall_ctrl_pkg.sv - shared types, stage indices and helpers for the stall controller
package stall_ctrl_pkg;

  localparam int STALL_W    = 6;
  localparam int REG_AW     = 5;
  localparam int LU_CNT_W   = 2;

  // Stage positions inside the stall vector
  localparam int STALL_ID   = 2;
  localparam int STALL_EX   = 3;
  localparam int STALL_DC   = 4;
  localparam int STALL_MEM  = 5;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_LU_WAIT   = 2'd1,
    ST_DIV_WAIT  = 2'd2,
    ST_MISS_WAIT = 2'd3
  } state_e;

  // Hold every stage from PC up to and including 'stage'
  function automatic logic [STALL_W-1:0] stall_through(input int stage);
    logic [STALL_W-1:0] m;
    m = '0;
    for (int i = 0; i < STALL_W; i++) begin
      if (i <= stage) m[i] = 1'b1;
    end
    return m;
  endfunction

  function automatic logic reads_reg(input logic rs_ren, input logic [REG_AW-1:0] rs,
                                     input logic rt_ren, input logic [REG_AW-1:0] rt,
                                     input logic [REG_AW-1:0] dst);
    return (rs_ren && (rs == dst)) || (rt_ren && (rt == dst));
  endfunction

endpackage

// File: rtl/stall_ctrl_load_use_detect.sv
// rtl/stall_ctrl_load_use_detect.sv - compares ID sources against EX/DCACHE load destinations
module stall_ctrl_load_use_detect
  import stall_ctrl_pkg::*;
(
  input  logic              id_valid_i,
  input  logic              rs_ren_i,
  input  logic [REG_AW-1:0] rs_raddr_i,
  input  logic              rt_ren_i,
  input  logic [REG_AW-1:0] rt_raddr_i,
  input  logic              ex_we_i,
  input  logic              ex_load_i,
  input  logic [REG_AW-1:0] ex_waddr_i,
  input  logic              dc_we_i,
  input  logic              dc_load_i,
  input  logic [REG_AW-1:0] dc_waddr_i,
  output logic              hit_o,
  output logic              need_two_o
);

  logic ex_ld_v;
  logic dc_ld_v;
  logic ex_hit;
  logic dc_hit;

  // $0 is hardwired, so a load targeting it can never create a hazard
  assign ex_ld_v = ex_we_i && ex_load_i && (ex_waddr_i != '0);
  assign dc_ld_v = dc_we_i && dc_load_i && (dc_waddr_i != '0);

  assign ex_hit = id_valid_i && ex_ld_v &&
                  reads_reg(rs_ren_i, rs_raddr_i, rt_ren_i, rt_raddr_i, ex_waddr_i);
  assign dc_hit = id_valid_i && dc_ld_v &&
                  reads_reg(rs_ren_i, rs_raddr_i, rt_ren_i, rt_raddr_i, dc_waddr_i);

  assign hit_o      = ex_hit || dc_hit;
  assign need_two_o = ex_hit;

endmodule

// File: rtl/stall_ctrl.sv
// rtl/stall_ctrl.sv - pipeline stall/bubble controller for load-use, divider and dcache miss
// Optional perf counters enabled by defining STALL_CTRL_PERF_EN.
module stall_ctrl
  import stall_ctrl_pkg::*;
#(
  parameter int PERF_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               id_valid,
  input  logic               id_rs_ren,
  input  logic [REG_AW-1:0]  id_rs_raddr,
  input  logic               id_rt_ren,
  input  logic [REG_AW-1:0]  id_rt_raddr,
  input  logic               ex_we,
  input  logic               ex_load,
  input  logic [REG_AW-1:0]  ex_waddr,
  input  logic               dc_we,
  input  logic               dc_load,
  input  logic [REG_AW-1:0]  dc_waddr,
  input  logic               dcache_miss,
  input  logic               div_start,
  input  logic               div_ready,
  output logic [STALL_W-1:0] stall,
  output logic               ex_bubble,
  output logic [PERF_W-1:0]  perf_stall_cnt,
  output logic [PERF_W-1:0]  perf_lu_cnt
);

  localparam logic [STALL_W-1:0] STALL_TO_ID = stall_through(STALL_ID);
  localparam logic [STALL_W-1:0] STALL_TO_EX = stall_through(STALL_EX);
  localparam logic [STALL_W-1:0] STALL_TO_DC = stall_through(STALL_DC);

  state_e              state_q, state_d;
  state_e              ret_q, ret_d;
  state_e              eff_state;
  logic [LU_CNT_W-1:0] lu_cnt_q, lu_cnt_d;
  logic                lu_hit;
  logic                lu_two;
  logic                div_go;
  logic [STALL_W-1:0]  stall_c;
  logic                bubble_c;

  stall_ctrl_load_use_detect u_lud (
    .id_valid_i (id_valid),
    .rs_ren_i   (id_rs_ren),
    .rs_raddr_i (id_rs_raddr),
    .rt_ren_i   (id_rt_ren),
    .rt_raddr_i (id_rt_raddr),
    .ex_we_i    (ex_we),
    .ex_load_i  (ex_load),
    .ex_waddr_i (ex_waddr),
    .dc_we_i    (dc_we),
    .dc_load_i  (dc_load),
    .dc_waddr_i (dc_waddr),
    .hit_o      (lu_hit),
    .need_two_o (lu_two)
  );

  // MISS_WAIT only parks the interrupted wait; once the miss clears we act as that state
  assign eff_state = (state_q == ST_MISS_WAIT) ? ret_q : state_q;
  assign div_go    = div_start && !div_ready;

  always_comb begin
    stall_c  = '0;
    bubble_c = 1'b0;
    if (rst || flush) begin
      stall_c  = '0;
    end else if (dcache_miss) begin
      stall_c  = STALL_TO_DC;
    end else begin
      case (eff_state)
        ST_DIV_WAIT: stall_c = STALL_TO_EX;
        ST_LU_WAIT: begin
          stall_c  = STALL_TO_ID;
          bubble_c = 1'b1;
        end
        default: begin
          if (lu_hit) begin
            stall_c  = STALL_TO_ID;
            bubble_c = 1'b1;
          end
        end
      endcase
    end
  end

  always_comb begin
    state_d  = state_q;
    ret_d    = ret_q;
    lu_cnt_d = lu_cnt_q;
    if (flush) begin
      state_d  = ST_RUN;
      ret_d    = ST_RUN;
      lu_cnt_d = '0;
    end else if (dcache_miss) begin
      // Freeze the pending wait, but still record a divider that finishes or starts meanwhile
      state_d = ST_MISS_WAIT;
      ret_d   = eff_state;
      if (eff_state == ST_DIV_WAIT && div_ready) begin
        ret_d = ST_RUN;
      end else if (eff_state == ST_RUN && div_go) begin
        ret_d = ST_DIV_WAIT;
      end
    end else begin
      ret_d = ST_RUN;
      case (eff_state)
        ST_LU_WAIT: begin
          if (lu_cnt_q <= LU_CNT_W'(1)) begin
            state_d  = ST_RUN;
            lu_cnt_d = '0;
          end else begin
            state_d  = ST_LU_WAIT;
            lu_cnt_d = lu_cnt_q - LU_CNT_W'(1);
          end
        end
        ST_DIV_WAIT: begin
          state_d = div_ready ? ST_RUN : ST_DIV_WAIT;
        end
        default: begin
          if (div_go) begin
            state_d  = ST_DIV_WAIT;
            lu_cnt_d = '0;
          end else if (lu_hit && lu_two) begin
            state_d  = ST_LU_WAIT;
            lu_cnt_d = LU_CNT_W'(1);
          end else begin
            state_d  = ST_RUN;
            lu_cnt_d = '0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_RUN;
      ret_q    <= ST_RUN;
      lu_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      ret_q    <= ret_d;
      lu_cnt_q <= lu_cnt_d;
    end
  end

  assign stall     = stall_c;
  assign ex_bubble = bubble_c;

`ifdef STALL_CTRL_PERF_EN
  logic [PERF_W-1:0] perf_stall_q;
  logic [PERF_W-1:0] perf_lu_q;

  // Bubbles are only ever issued for load-use, so ex_bubble marks a load-use stall cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_q <= '0;
      perf_lu_q    <= '0;
    end else begin
      if (stall_c != '0) perf_stall_q <= perf_stall_q + PERF_W'(1);
      if (bubble_c)      perf_lu_q    <= perf_lu_q + PERF_W'(1);
    end
  end

  assign perf_stall_cnt = perf_stall_q;
  assign perf_lu_cnt    = perf_lu_q;
`else
  assign perf_stall_cnt = '0;
  assign perf_lu_cnt    = '0;
`endif

endmodule

// File: tb/tb_stall_ctrl.sv
// tb/tb_stall_ctrl.sv - directed table-driven bench for stall_ctrl (honours STALL_CTRL_PERF_EN)
module tb_stall_ctrl;

  typedef struct {
    logic       fl;
    logic       idv;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       ex_we;
    logic       ex_ld;
    logic [4:0] exa;
    logic       dc_we;
    logic       dc_ld;
    logic [4:0] dca;
    logic       miss;
    logic       ds;
    logic       dr;
    logic [5:0] es;
    logic       eb;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        id_valid;
  logic        id_rs_ren;
  logic [4:0]  id_rs_raddr;
  logic        id_rt_ren;
  logic [4:0]  id_rt_raddr;
  logic        ex_we;
  logic        ex_load;
  logic [4:0]  ex_waddr;
  logic        dc_we;
  logic        dc_load;
  logic [4:0]  dc_waddr;
  logic        dcache_miss;
  logic        div_start;
  logic        div_ready;
  logic [5:0]  stall;
  logic        ex_bubble;
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_lu_cnt;

  int n_checks;
  int n_errors;
  int exp_pstall;
  int exp_plu;
  vec_t vecs[$];

  stall_ctrl #(.PERF_W(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .id_valid       (id_valid),
    .id_rs_ren      (id_rs_ren),
    .id_rs_raddr    (id_rs_raddr),
    .id_rt_ren      (id_rt_ren),
    .id_rt_raddr    (id_rt_raddr),
    .ex_we          (ex_we),
    .ex_load        (ex_load),
    .ex_waddr       (ex_waddr),
    .dc_we          (dc_we),
    .dc_load        (dc_load),
    .dc_waddr       (dc_waddr),
    .dcache_miss    (dcache_miss),
    .div_start      (div_start),
    .div_ready      (div_ready),
    .stall          (stall),
    .ex_bubble      (ex_bubble),
    .perf_stall_cnt (perf_stall_cnt),
    .perf_lu_cnt    (perf_lu_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // exk/dck: 0 = no GPR write, 1 = ALU write, 2 = load
  function automatic vec_t mk(input logic fl, input logic idv, input int rs, input int rt,
                              input int exk, input int exa, input int dck, input int dca,
                              input logic miss, input logic ds, input logic dr,
                              input logic [5:0] es, input logic eb);
    vec_t v;
    v.fl = fl; v.idv = idv; v.rs = 5'(rs); v.rt = 5'(rt);
    v.ex_we = (exk != 0); v.ex_ld = (exk == 2); v.exa = 5'(exa);
    v.dc_we = (dck != 0); v.dc_ld = (dck == 2); v.dca = 5'(dca);
    v.miss = miss; v.ds = ds; v.dr = dr; v.es = es; v.eb = eb;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    flush       = v.fl;
    id_valid    = v.idv;
    id_rs_ren   = v.idv;
    id_rt_ren   = v.idv;
    id_rs_raddr = v.rs;
    id_rt_raddr = v.rt;
    ex_we       = v.ex_we;
    ex_load     = v.ex_ld;
    ex_waddr    = v.exa;
    dc_we       = v.dc_we;
    dc_load     = v.dc_ld;
    dc_waddr    = v.dca;
    dcache_miss = v.miss;
    div_start   = v.ds;
    div_ready   = v.dr;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    exp_pstall = 0;
    exp_plu = 0;

    // idle
    vecs.push_back(mk(0,0,0,0, 0,0,0,0, 0,0,0, 6'h00,0));
    // lw $5 in EX, ID reads $5: two bubbles
    vecs.push_back(mk(0,1,5,6, 2,5,0,0, 0,0,0, 6'h07,1));
    vecs.push_back(mk(0,1,5,6, 0,0,2,5, 0,0,0, 6'h07,1));
    vecs.push_back(mk(0,1,5,6, 0,0,0,0, 0,0,0, 6'h00,0));
    // ALU writers never stall
    vecs.push_back(mk(0,1,5,6, 1,5,1,6, 0,0,0, 6'h00,0));
    // lw $5 only in DCACHE, ID reads rt=$5: one bubble
    vecs.push_back(mk(0,1,1,5, 0,0,2,5, 0,0,0, 6'h07,1));
    vecs.push_back(mk(0,1,1,5, 0,0,0,0, 0,0,0, 6'h00,0));
    // lw $0 never hazards
    vecs.push_back(mk(0,1,0,0, 2,0,0,0, 0,0,0, 6'h00,0));
    vecs.push_back(mk(0,1,0,0, 0,0,2,0, 0,0,0, 6'h00,0));
    // no real instruction in ID
    vecs.push_back(mk(0,0,5,5, 2,5,2,5, 0,0,0, 6'h00,0));
    // loads in both EX and DCACHE hit: two bubbles
    vecs.push_back(mk(0,1,5,6, 2,5,2,6, 0,0,0, 6'h07,1));
    vecs.push_back(mk(0,1,5,6, 0,0,2,5, 0,0,0, 6'h07,1));
    vecs.push_back(mk(0,1,5,6, 0,0,0,0, 0,0,0, 6'h00,0));
    // divide, ready 5 cycles later
    vecs.push_back(mk(0,0,0,0, 0,0,0,0, 0,1,0, 6'h00,0));
    for (int i = 0; i < 4; i++) vecs.push_back(mk(0,0,0,0, 0,0,0,0, 0,0,0, 6'h0F,0));
    vecs.push_back(mk(0,0,0,0, 0,0,0,0, 0,0,1, 6'h0F,0));
    vecs.push_back(mk(0,0,0,0, 0,0,0,0, 0,0,0, 6'h00,0));
    // single-cycle divide
    vecs.push_back(mk(0,0,0,0, 0,0,0,0, 0,1,1, 6'h00,0));
    vecs.push_back(mk(0,0,0,0, 0,0,0,0, 0,0,0, 6'h00,0));
    // miss for 3 cycles in LU_WAIT, then the remaining bubble
    vecs.push_back(mk(0,1,5,6, 2,5,0,0, 0,0,0, 6'h07,1));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(0,1,5,6, 0,0,2,5, 1,0,0, 6'h1F,0));
    vecs.push_back(mk(0,1,5,6, 0,0,2,5, 0,0,0, 6'h07,1));
    vecs.push_back(mk(0,1,5,6, 0,0,0,0, 0,0,0, 6'h00,0));
    // plain miss from RUN
    vecs.push_back(mk(0,0,0,0, 0,0,0,0, 1,0,0, 6'h1F,0));
    vecs.push_back(mk(0,0,0,0, 0,0,0,0, 1,0,0, 6'h1F,0));
    vecs.push_back(mk(0,0,0,0, 0,0,0,0, 0,0,0, 6'h00,0));
    // load-use masked by miss, re-evaluated after it clears
    vecs.push_back(mk(0,1,5,6, 2,5,0,0, 1,0,0, 6'h1F,0));
    vecs.push_back(mk(0,1,5,6, 2,5,0,0, 0,0,0, 6'h07,1));
    vecs.push_back(mk(0,1,5,6, 0,0,2,5, 0,0,0, 6'h07,1));
    vecs.push_back(mk(0,1,5,6, 0,0,0,0, 0,0,0, 6'h00,0));
    // divider completes while a miss is pending
    vecs.push_back(mk(0,0,0,0, 0,0,0,0, 0,1,0, 6'h00,0));
    vecs.push_back(mk(0,0,0,0, 0,0,0,0, 0,0,0, 6'h0F,0));
    vecs.push_back(mk(0,0,0,0, 0,0,0,0, 1,0,0, 6'h1F,0));
    vecs.push_back(mk(0,0,0,0, 0,0,0,0, 1,0,1, 6'h1F,0));
    vecs.push_back(mk(0,0,0,0, 0,0,0,0, 0,0,0, 6'h00,0));
    // divider wait resumed after a miss
    vecs.push_back(mk(0,0,0,0, 0,0,0,0, 0,1,0, 6'h00,0));
    vecs.push_back(mk(0,0,0,0, 0,0,0,0, 0,0,0, 6'h0F,0));
    vecs.push_back(mk(0,0,0,0, 0,0,0,0, 1,0,0, 6'h1F,0));
    vecs.push_back(mk(0,0,0,0, 0,0,0,0, 0,0,0, 6'h0F,0));
    vecs.push_back(mk(0,0,0,0, 0,0,0,0, 0,0,1, 6'h0F,0));
    vecs.push_back(mk(0,0,0,0, 0,0,0,0, 0,0,0, 6'h00,0));
    // div_start together with a DCACHE load-use: bubble now, divider wait next
    vecs.push_back(mk(0,1,1,5, 0,0,2,5, 0,1,0, 6'h07,1));
    vecs.push_back(mk(0,0,0,0, 0,0,0,0, 0,0,0, 6'h0F,0));
    vecs.push_back(mk(0,0,0,0, 0,0,0,0, 0,0,1, 6'h0F,0));
    vecs.push_back(mk(0,0,0,0, 0,0,0,0, 0,0,0, 6'h00,0));
    // flush in the detect cycle
    vecs.push_back(mk(1,1,5,6, 2,5,0,0, 0,0,0, 6'h00,0));
    vecs.push_back(mk(0,0,0,0, 0,0,0,0, 0,0,0, 6'h00,0));
    // flush during LU_WAIT
    vecs.push_back(mk(0,1,5,6, 2,5,0,0, 0,0,0, 6'h07,1));
    vecs.push_back(mk(1,1,5,6, 0,0,2,5, 0,0,0, 6'h00,0));
    vecs.push_back(mk(0,0,0,0, 0,0,0,0, 0,0,0, 6'h00,0));
    // flush during DIV_WAIT; a later div_ready is ignored
    vecs.push_back(mk(0,0,0,0, 0,0,0,0, 0,1,0, 6'h00,0));
    vecs.push_back(mk(0,0,0,0, 0,0,0,0, 0,0,0, 6'h0F,0));
    vecs.push_back(mk(0,0,0,0, 0,0,0,0, 0,0,0, 6'h0F,0));
    vecs.push_back(mk(1,0,0,0, 0,0,0,0, 0,0,0, 6'h00,0));
    vecs.push_back(mk(0,0,0,0, 0,0,0,0, 0,0,1, 6'h00,0));
    vecs.push_back(mk(0,0,0,0, 0,0,0,0, 0,0,0, 6'h00,0));
    // flush beats a miss
    vecs.push_back(mk(1,0,0,0, 0,0,0,0, 1,0,0, 6'h00,0));
    vecs.push_back(mk(0,0,0,0, 0,0,0,0, 0,0,0, 6'h00,0));

    // reset state, with a miss already pending to show async gating
    rst = 1'b1;
    drive(mk(0,0,0,0, 0,0,0,0, 1,0,0, 6'h00,0));
    #12;
    chk("reset stall", 32'(stall), 32'h0);
    chk("reset bubble", 32'(ex_bubble), 32'h0);
    chk("reset perf_stall", perf_stall_cnt, 32'h0);
    chk("reset perf_lu", perf_lu_cnt, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i]);
      #3;
      chk($sformatf("row%0d stall", i), 32'(stall), 32'(vecs[i].es));
      chk($sformatf("row%0d bubble", i), 32'(ex_bubble), 32'(vecs[i].eb));
      if (vecs[i].es != 6'h00) exp_pstall++;
      if (vecs[i].eb) exp_plu++;
      next_cycle();
    end

`ifdef STALL_CTRL_PERF_EN
    chk("perf_stall total", perf_stall_cnt, 32'(exp_pstall));
    chk("perf_lu total", perf_lu_cnt, 32'(exp_plu));
`else
    chk("perf_stall tied", perf_stall_cnt, 32'h0);
    chk("perf_lu tied", perf_lu_cnt, 32'h0);
`endif

    // reset mid-miss while a divide is parked
    drive(mk(0,0,0,0, 0,0,0,0, 0,1,0, 6'h00,0));
    #3;
    chk("rst seq div_start", 32'(stall), 32'h00);
    next_cycle();
    drive(mk(0,0,0,0, 0,0,0,0, 0,0,0, 6'h00,0));
    #3;
    chk("rst seq div_wait", 32'(stall), 32'h0F);
    next_cycle();
    drive(mk(0,0,0,0, 0,0,0,0, 1,0,0, 6'h00,0));
    #3;
    chk("rst seq miss", 32'(stall), 32'h1F);
    #2;
    rst = 1'b1;
    #1;
    chk("async rst stall", 32'(stall), 32'h0);
    chk("async rst bubble", 32'(ex_bubble), 32'h0);
    chk("async rst perf_stall", perf_stall_cnt, 32'h0);
    chk("async rst perf_lu", perf_lu_cnt, 32'h0);
    next_cycle();
    rst = 1'b0;
    drive(mk(0,0,0,0, 0,0,0,0, 0,0,0, 6'h00,0));
    #3;
    chk("post rst state RUN", 32'(stall), 32'h00);
    next_cycle();
    drive(mk(0,1,7,3, 2,7,0,0, 0,0,0, 6'h00,0));
    #3;
    chk("post rst lu stall", 32'(stall), 32'h07);
    chk("post rst lu bubble", 32'(ex_bubble), 32'h1);
    next_cycle();
    drive(mk(0,0,0,0, 0,0,0,0, 0,0,0, 6'h00,0));
`ifdef STALL_CTRL_PERF_EN
    chk("post rst perf_lu", perf_lu_cnt, 32'h1);
`else
    chk("post rst perf_lu tied", perf_lu_cnt, 32'h0);
`endif
    next_cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
